regfile_read_arbiter: RTL
=========================

// Module: regfile_read_arbiter
// PURPOSE
//  Shares one 32-entry x 32-bit read port (a 5-bit-select 32:1 mux) between NREQ requesters.
//  Round-robin arbitration, one read per cycle; drives the mux select and registers the returned word.
//  Tags each returned word with the winning requester ID.
//  Sits between the CPU/sprite/audio readers and the mux that fronts the register/state file.
// PARAMETERS
//  NREQ      4   number of requesters, 2..8
//  IDW       2   requester ID width, ceil(log2(NREQ))
//  LOCK_MAX  8   max consecutive locked grants (used only with ARB_LOCK_EN)
// PORTS
//  clock     in   1          system clock, all state on rising edge
//  reset     in   1          synchronous, active-high
//  req       in   NREQ       req[i]=1: requester i presents a read on addr slice i
//  addr      in   5*NREQ     addr[5i+4:5i] = entry index for requester i
//  lock      in   NREQ       hold-grant request (ARB_LOCK_EN only; otherwise ignored)
//  gnt       out  NREQ       registered one-hot grant; gnt[i]=1 => read from previous edge accepted
//  mux_sel   out  5          registered select to the 32:1 mux
//  mux_data  in   32         combinational mux output for mux_sel
//  rdata     out  32         registered read data
//  rvalid    out  1          rdata valid this cycle
//  rid       out  IDW        requester that owns rdata
// BEHAVIOUR
//  - Reset (sync): gnt=0, mux_sel=0, rdata=0, rvalid=0, rid=0, ptr=NREQ-1, lock_cnt=0.
//    Reset mid-read drops the in-flight word: rvalid=0 on the cycle after reset; no late rvalid.
//  - Arbitration at each edge: winner = first i with req[i]=1, scanning ptr+1, ptr+2, ... mod NREQ.
//    With a winner w: gnt<=onehot(w), mux_sel<=addr[w], ptr<=w, pend<=1, pend_id<=w.
//    With no request: gnt<=0, pend<=0, mux_sel holds its last value, ptr holds.
//  - Data stage: at the edge after a grant, rdata<=mux_data, rid<=pend_id, rvalid<=pend.
//    On idle cycles rvalid<=0; rdata and rid hold.
//  - Latency: req/addr sampled at edge t; gnt and mux_sel valid during cycle t+1; rdata/rvalid valid during t+2.
//    Fully pipelined: one word per cycle when req is continuously non-zero.
//  - Handshake: req is a level. The requester holds req and addr until it sees gnt[i].
//    In the gnt cycle it may present the next addr (req stays 1) or drop req combinationally.
//    A req still high at the following edge counts as a new read.
//  - Fairness: a continuously requesting master waits at most NREQ-1 grants (no lock).
//  - Simultaneous req and reset: reset wins, no grant issued.
//  - Addresses are 5-bit, so every value 0..31 is legal; no range check.
// CONFIGURATION
//  ARB_LOCK_EN defined:
//    - If the previous winner w still has req[w]&lock[w] and lock_cnt<LOCK_MAX-1, w is granted again;
//      ptr is not advanced and lock_cnt increments.
//    - Otherwise normal round-robin applies and lock_cnt<=0.
//    - So one master gets at most LOCK_MAX consecutive locked grants, then must yield once.
//  ARB_LOCK_EN undefined: lock port present but ignored; no lock_cnt logic; pure round-robin.
// TESTING
//  1. Hold reset 2 cycles -> all outputs 0. Then req=0001, addr0=5, mux model mem[k]=k*0x11111111
//     -> gnt=0001 and mux_sel=5 in cycle 1; rdata=0x55555555, rvalid=1, rid=0 in cycle 2.
//  2. req=1111 held, addr_i=i+8 -> gnt 0001,0010,0100,1000,0001...; rid 0,1,2,3,0 lagging gnt by 1;
//     rvalid=1 every cycle.
//  3. From reset, req=1010 held -> grants go to requester 1, 3, 1, 3; requesters 0 and 2 are never granted.
//  4. Grant issued to requester 2; reset asserted in the next cycle -> rvalid=0 thereafter.
//     After release, req=1111 -> first grant goes to requester 0.
//  5. ARB_LOCK_EN, LOCK_MAX=8: req=1111, lock=0100 after requester 2 wins -> requester 2 granted 8 cycles in a row,
//     then requester 3. Without the macro, same stimulus -> plain rotation 2,3,0,1.
//  6. req drops to 0000 after one grant to requester 1 (addr=17) -> gnt=0, mux_sel stays 17;
//     rvalid=1 for exactly one cycle, then 0; rdata holds.

Source files
------------

// File: rtl/regfile_read_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_read_arbiter
//  Purpose  : Round-robin arbiter that shares one 32x32 register-file read
//             mux among NREQ requesters and returns ID-tagged read data.
//  Options  : ARB_LOCK_EN  - let a requester hold the grant for up to
//                            LOCK_MAX consecutive reads.
//  Revision : 1.0  initial release
// ============================================================================
module regfile_read_arbiter #(
    parameter int NREQ     = 4,
    parameter int IDW      = 2,
    parameter int LOCK_MAX = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    input  logic [5*NREQ-1:0] addr,
    input  logic [NREQ-1:0]   lock,
    output logic [NREQ-1:0]   gnt,
    output logic [4:0]        mux_sel,
    input  logic [31:0]       mux_data,
    output logic [31:0]       rdata,
    output logic              rvalid,
    output logic [IDW-1:0]    rid
);

    localparam logic [IDW-1:0] c_ptr_rst = IDW'(NREQ - 1);

    logic [NREQ-1:0] r_gnt;
    logic [4:0]      r_mux_sel;
    logic [31:0]     r_rdata;
    logic            r_rvalid;
    logic [IDW-1:0]  r_rid;
    logic [IDW-1:0]  r_ptr;
    logic            r_pend;
    logic [IDW-1:0]  r_pend_id;

    logic            w_rr_found;
    logic [IDW-1:0]  w_rr_win;
    logic            w_found;
    logic [IDW-1:0]  w_win;

    // Requester index k positions after ptr, wrapping at NREQ (need not be a power of two).
    function automatic logic [IDW-1:0] rr_index(input logic [IDW-1:0] ptr, input int k);
        int s;
        s = int'(ptr) + k;
        if (s >= NREQ) begin
            s = s - NREQ;
        end
        return IDW'(s);
    endfunction

    always_comb begin
        w_rr_found = 1'b0;
        w_rr_win   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!w_rr_found && req[rr_index(r_ptr, k)]) begin
                w_rr_found = 1'b1;
                w_rr_win   = rr_index(r_ptr, k);
            end
        end
    end

`ifdef ARB_LOCK_EN
    localparam int CW = $clog2(LOCK_MAX + 1);

    logic [CW-1:0] r_lock_cnt;
    logic          w_lock_hold;

    // Only a grant issued on the immediately preceding edge can be extended.
    assign w_lock_hold = r_pend && req[r_ptr] && lock[r_ptr]
                         && (int'(r_lock_cnt) < LOCK_MAX - 1);
    assign w_found     = w_lock_hold || w_rr_found;
    assign w_win       = w_lock_hold ? r_ptr : w_rr_win;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_lock_cnt <= '0;
        end else if (w_lock_hold) begin
            r_lock_cnt <= r_lock_cnt + CW'(1);
        end else begin
            r_lock_cnt <= '0;
        end
    end
`else
    logic w_unused_lock;

    assign w_unused_lock = ^lock;
    assign w_found       = w_rr_found;
    assign w_win         = w_rr_win;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            r_gnt     <= '0;
            r_mux_sel <= '0;
            r_rdata   <= '0;
            r_rvalid  <= 1'b0;
            r_rid     <= '0;
            r_ptr     <= c_ptr_rst;
            r_pend    <= 1'b0;
            r_pend_id <= '0;
        end else begin
            // Grant stage
            if (w_found) begin
                r_gnt     <= NREQ'(1) << w_win;
                r_mux_sel <= addr[5*int'(w_win) +: 5];
                r_ptr     <= w_win;
                r_pend    <= 1'b1;
                r_pend_id <= w_win;
            end else begin
                r_gnt     <= '0;
                r_pend    <= 1'b0;
            end
            // Data stage: mux_data reflects the select registered on the previous edge
            r_rvalid <= r_pend;
            if (r_pend) begin
                r_rdata <= mux_data;
                r_rid   <= r_pend_id;
            end
        end
    end

    assign gnt     = r_gnt;
    assign mux_sel = r_mux_sel;
    assign rdata   = r_rdata;
    assign rvalid  = r_rvalid;
    assign rid     = r_rid;

endmodule
`default_nettype wire
